// File: rtl/config_uart_pkg.sv
// Shared definitions for the configuration-port UART pair (tx and rx).
// The receiver uses baud_divisor too, so both sides agree on the bit period.
package config_uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  typedef struct packed {
    logic                      start;
    logic [UART_DATA_BITS-1:0] data;
  } byte_req_t;

  function automatic int baud_divisor(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction
endpackage

// File: rtl/config_uart_tx_byte.sv
// 8N1 byte serialiser. A start request taken in IDLE or in the final stop-bit
// cycle chains the next frame with no idle gap. done marks that final cycle.
module config_uart_tx_byte
  import config_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic      CLK,
  input  logic      resetn,
  input  byte_req_t req,
  output logic      tx,
  output logic      busy,
  output logic      done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_e                 state, state_nxt;
  logic [CNT_W-1:0]          baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      baud_last;

  assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT-1));

  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req.start) state_nxt = START;
      START:   if (baud_last) state_nxt = DATA;
      DATA:    if (baud_last && bit_idx == 3'(UART_DATA_BITS-1)) state_nxt = STOP;
      STOP:    if (baud_last) state_nxt = req.start ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Baud counter restarts on every state entry so each frame is phase-aligned.
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      baud_cnt <= (state == IDLE || state_nxt != state || baud_last) ? '0 : baud_cnt + 1'b1;
      if (state == START)                 bit_idx <= '0;
      else if (state == DATA && baud_last) bit_idx <= bit_idx + 1'b1;
      if (req.start)                      shift <= req.data;
      else if (state == DATA && baud_last) shift <= shift >> 1;
    end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    done = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      START:   tx   = 1'b0;
      DATA:    tx   = shift[0];
      STOP:    done = baud_last;
      default: ;
    endcase
  end
endmodule

// File: rtl/config_uart_tx.sv
// Config-port UART transmitter: takes 32-bit words on valid/ready and sends
// them as four back-to-back 8N1 frames, most-significant byte first.
module config_uart_tx
  import config_uart_pkg::*;
#(
  parameter int BAUD_RATE       = 115_200,
  parameter int CLOCK_FREQUENCY = 100_000_000
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [31:0] TxData,
  input  logic        TxValid,
  output logic        TxReady,
  output logic        Tx,
  output logic        TxActive,
  output logic        TransmitLED
);
  localparam int CLKS_PER_BIT = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int WORD_W       = UART_DATA_BITS * BYTES_PER_WORD;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("config_uart_tx: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  logic [WORD_W-1:0] word;
  logic [1:0]        byte_idx;
  logic              busy, done, accept, next_byte;
  byte_req_t         req;

  assign TxReady   = !busy;
  assign TxActive  = busy;
  assign accept    = TxValid && TxReady;
  assign next_byte = done && (byte_idx != 2'(BYTES_PER_WORD-1));
  assign req.start = accept || next_byte;
  // The outgoing byte always sits in the top of word; it is shifted up per frame.
  assign req.data  = accept ? TxData[WORD_W-1 -: UART_DATA_BITS]
                            : word[WORD_W-1 -: UART_DATA_BITS];

  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      word        <= '0;
      byte_idx    <= '0;
      TransmitLED <= 1'b0;
    end else if (accept) begin
      word        <= TxData << UART_DATA_BITS;
      byte_idx    <= '0;
      TransmitLED <= ~TransmitLED;
    end else if (next_byte) begin
      word        <= word << UART_DATA_BITS;
      byte_idx    <= byte_idx + 1'b1;
      TransmitLED <= ~TransmitLED;
    end

  config_uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .CLK    (CLK),
    .resetn (resetn),
    .req    (req),
    .tx     (Tx),
    .busy   (busy),
    .done   (done)
  );
endmodule

// File: tb/tb_config_uart_tx.sv
// Bench for config_uart_tx: a per-cycle line model built from word -> frame
// bit expansion, driven with directed and random traffic, plus a bit-period check.
module tb_config_uart_tx;
  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int CPB = CF / BR;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [31:0] TxData = '0;
  logic        TxValid = 1'b0;
  logic        TxReady, Tx, TxActive, TransmitLED;

  logic        f_resetn;
  logic [31:0] f_data = '0;
  logic        f_valid = 1'b0;
  logic        f_ready, f_tx, f_active, f_led;

  always #5 CLK = ~CLK;

  config_uart_tx #(.BAUD_RATE(BR), .CLOCK_FREQUENCY(CF)) dut (
    .CLK(CLK), .resetn(resetn), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady), .Tx(Tx), .TxActive(TxActive), .TransmitLED(TransmitLED)
  );

  config_uart_tx dut_fast (
    .CLK(CLK), .resetn(f_resetn), .TxData(f_data), .TxValid(f_valid),
    .TxReady(f_ready), .Tx(f_tx), .TxActive(f_active), .TransmitLED(f_led)
  );

  typedef struct { logic lvl; logic first; } slot_t;
  slot_t line_q[$];
  logic  led_exp = 1'b0;
  int    n_chk = 0, n_fail = 0, n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected line: per byte MSB-first, frame = start(0), 8 data LSB-first, stop(1).
  task automatic push_word(input logic [31:0] w);
    logic [7:0] by;
    logic       lvl;
    for (int b = 3; b >= 0; b--) begin
      by = w[b*8 +: 8];
      for (int s = 0; s < 10; s++) begin
        lvl = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : by[s-1];
        for (int c = 0; c < CPB; c++) line_q.push_back('{lvl, (s == 0 && c == 0)});
      end
    end
  endtask

  // Sample {Tx,TxActive,TxReady,TransmitLED} on the falling edge, then drive
  // inputs for the next rising edge; the model accepts only when its line is idle.
  task automatic step(input logic v, input logic [31:0] d, input string tag);
    logic idle, etx;
    @(negedge CLK);
    if (line_q.size() != 0 && line_q[0].first) led_exp = ~led_exp;
    idle = (line_q.size() == 0);
    etx  = idle ? 1'b1 : line_q[0].lvl;
    chk(tag, {28'd0, Tx, TxActive, TxReady, TransmitLED},
             {28'd0, etx, !idle, idle, led_exp});
    if (!idle) void'(line_q.pop_front());
    TxValid = v;
    TxData  = d;
    if (v && idle) begin
      push_word(d);
      n_acc++;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && line_q.size() != 0; i++) step(1'b0, $urandom, tag);
    chk({tag, "_timeout"}, line_q.size(), 0);
    step(1'b0, $urandom, tag);
    step(1'b0, $urandom, tag);
  endtask

  initial begin
    int n;
    resetn   = 1'b1;
    f_resetn = 1'b1;
    #1;
    resetn   = 1'b0;
    f_resetn = 1'b0;
    #2;
    chk("reset_outs", {28'd0, Tx, TxActive, TxReady, TransmitLED}, 32'hA);
    repeat (3) @(negedge CLK);
    resetn = 1'b1;

    // Idle hold
    for (int i = 0; i < 100; i++) step(1'b0, $urandom, "idle");

    // Single word, data wiggled while busy
    step(1'b1, 32'hA5C30F01, "single");
    drain("single");

    // Back-to-back with TxValid held
    n = n_acc;
    step(1'b1, 32'h12345678, "b2b");
    for (int i = 0; i < 2000 && n_acc < n + 2; i++) step(1'b1, 32'hDEADBEEF, "b2b");
    chk("b2b_accepts", n_acc - n, 2);
    drain("b2b");

    // Valid pulse during byte 2 is ignored
    n = n_acc;
    step(1'b1, $urandom, "busy_pulse");
    for (int i = 0; i < 250; i++) step(1'b0, $urandom, "busy_pulse");
    step(1'b1, 32'hFFFFFFFF, "busy_pulse");
    drain("busy_pulse");
    chk("busy_accepts", n_acc - n, 1);

    // Async reset mid-bit of byte 1, then an all-zero word
    step(1'b1, $urandom, "rst_mid");
    for (int i = 0; i < 153; i++) step(1'b0, $urandom, "rst_mid");
    #2 resetn = 1'b0;
    #1 chk("rst_mid_outs", {28'd0, Tx, TxActive, TxReady, TransmitLED}, 32'hA);
    line_q.delete();
    led_exp = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    step(1'b0, $urandom, "post_rst");
    step(1'b1, 32'h0, "zero_word");
    drain("zero_word");

    // Random traffic
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 4) == 0, $urandom, "rand");
    drain("rand");

    // Default-parameter instance: CLKS_PER_BIT = 868
    @(negedge CLK);
    f_resetn = 1'b1;
    @(negedge CLK);
    f_valid = 1'b1;
    f_data  = 32'h55000000;
    @(negedge CLK);
    f_valid = 1'b0;
    chk("fast_active", {31'd0, f_active}, 1);
    chk("fast_led", {31'd0, f_led}, 1);
    n = 0;
    while (f_tx == 1'b0 && n < 2000) begin n++; @(negedge CLK); end
    chk("fast_start_period", n, 868);
    n = 0;
    while (f_tx == 1'b1 && n < 2000) begin n++; @(negedge CLK); end
    chk("fast_bit0_period", n, 868);
    f_resetn = 1'b0;
    #1 chk("fast_rst_tx", {31'd0, f_tx}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
